// File: rtl/color_bar_check.sv
// color_bar_check: video timing measurement, lock detection and colour-bar
// pixel checker for a raster source (hs/vs/de + 8-bit RGB).
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   hs, vs, de               line sync, frame sync, data enable (active-high)
//   rgb_r, rgb_g, rgb_b      pixel components
//   err_clr                  synchronous clear of err_cnt (wins over a pix_err)
//   h_total_meas             clocks between hs rising edges
//   h_active_meas            de-high clocks in the last completed de run
//   v_total_meas             hs rising edges in the last completed frame
//   v_active_meas            de rising edges in the last completed frame
//   locked                   timing has matched the parameters long enough
//   frame_done               one-cycle pulse per completed frame
//   pix_err                  one-cycle pulse per mismatching pixel
//   err_cnt                  saturating count of pix_err pulses
module color_bar_check #(
    parameter int unsigned H_ACTIVE    = 1920,
    parameter int unsigned V_ACTIVE    = 1080,
    parameter int unsigned H_TOTAL     = 2200,
    parameter int unsigned V_TOTAL     = 1125,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    input  logic [7:0]  rgb_r,
    input  logic [7:0]  rgb_g,
    input  logic [7:0]  rgb_b,
    input  logic        err_clr,
    output logic [11:0] h_total_meas,
    output logic [11:0] h_active_meas,
    output logic [11:0] v_total_meas,
    output logic [11:0] v_active_meas,
    output logic        locked,
    output logic        frame_done,
    output logic        pix_err,
    output logic [15:0] err_cnt
);

    localparam int unsigned CW     = 12;
    localparam int unsigned EW     = 16;
    localparam int unsigned MW     = 4;
    localparam int unsigned BAND_W = H_ACTIVE / 8;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [EW-1:0] ERR_MAX = {EW{1'b1}};

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // Saturating 12-bit increment shared by all measurement counters.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Input registers and one-deep delay for edge detection
    // ------------------------------------------------------------------
    logic       hs_r, vs_r, de_r;
    logic       hs_d, vs_d, de_d;
    logic [7:0] r_r, g_r, b_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_r <= 1'b0;
            vs_r <= 1'b0;
            de_r <= 1'b0;
            hs_d <= 1'b0;
            vs_d <= 1'b0;
            de_d <= 1'b0;
            r_r  <= 8'd0;
            g_r  <= 8'd0;
            b_r  <= 8'd0;
        end else begin
            hs_r <= hs;
            vs_r <= vs;
            de_r <= de;
            hs_d <= hs_r;
            vs_d <= vs_r;
            de_d <= de_r;
            r_r  <= rgb_r;
            g_r  <= rgb_g;
            b_r  <= rgb_b;
        end
    end

    logic hs_rise, vs_rise, de_rise, de_fall;

    assign hs_rise = hs_r & ~hs_d;
    assign vs_rise = vs_r & ~vs_d;
    assign de_rise = de_r & ~de_d;
    assign de_fall = ~de_r & de_d;

    // ------------------------------------------------------------------
    // Horizontal measurement
    // ------------------------------------------------------------------
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] h_act_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt         <= '0;
            h_act_cnt     <= '0;
            h_total_meas  <= '0;
            h_active_meas <= '0;
        end else begin
            // The hs-rise clock itself is clock 1 of the new line.
            if (hs_rise) begin
                h_total_meas <= h_cnt;
                h_cnt        <= CW'(1);
            end else begin
                h_cnt <= sat_inc(h_cnt);
            end

            if (hs_rise) begin
                h_act_cnt <= '0;
            end else if (de_r) begin
                h_act_cnt <= sat_inc(h_act_cnt);
            end

            if (de_fall) begin
                h_active_meas <= h_act_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Vertical measurement, arming and frame_done generation
    // ------------------------------------------------------------------
    logic [CW-1:0] v_hs_cnt;
    logic [CW-1:0] v_de_cnt;
    logic          armed;
    logic          v_latch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_hs_cnt      <= '0;
            v_de_cnt      <= '0;
            v_total_meas  <= '0;
            v_active_meas <= '0;
            armed         <= 1'b0;
            v_latch       <= 1'b0;
        end else begin
            v_latch <= 1'b0;
            if (vs_rise) begin
                // An hs/de edge coincident with vs belongs to the new frame.
                v_hs_cnt <= hs_rise ? CW'(1) : CW'(0);
                v_de_cnt <= de_rise ? CW'(1) : CW'(0);
                // The frame preceding the first vs after reset is partial.
                if (armed) begin
                    v_total_meas  <= v_hs_cnt;
                    v_active_meas <= v_de_cnt;
                    v_latch       <= 1'b1;
                end
                armed <= 1'b1;
            end else begin
                if (hs_rise) begin
                    v_hs_cnt <= sat_inc(v_hs_cnt);
                end
                if (de_rise) begin
                    v_de_cnt <= sat_inc(v_de_cnt);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= v_latch;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM, evaluated on each frame_done
    // ------------------------------------------------------------------
    logic        frame_match;
    lock_state_t state;
    logic [MW-1:0] match_cnt;

    assign frame_match = (h_total_meas  == CW'(H_TOTAL))  &&
                         (h_active_meas == CW'(H_ACTIVE)) &&
                         (v_total_meas  == CW'(V_TOTAL))  &&
                         (v_active_meas == CW'(V_ACTIVE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= UNLOCK;
            match_cnt <= '0;
            locked    <= 1'b0;
        end else if (frame_done) begin
            if (!frame_match) begin
                state     <= UNLOCK;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else begin
                case (state)
                    UNLOCK: begin
                        match_cnt <= MW'(1);
                        if (LOCK_FRAMES <= 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state  <= CHECK;
                            locked <= 1'b0;
                        end
                    end
                    CHECK: begin
                        match_cnt <= match_cnt + MW'(1);
                        if ((match_cnt + MW'(1)) >= MW'(LOCK_FRAMES)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state  <= CHECK;
                            locked <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                    default: begin
                        state     <= UNLOCK;
                        match_cnt <= '0;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel position within the current de run
    // ------------------------------------------------------------------
    logic [CW-1:0] x_q;
    logic [CW-1:0] x_cur;

    // x of the pixel currently held in the input registers.
    assign x_cur = de_rise ? '0 : sat_inc(x_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
        end else if (de_r) begin
            x_q <= x_cur;
        end
    end

    // ------------------------------------------------------------------
    // Expected colour: band index from constant boundaries, no divider
    // ------------------------------------------------------------------
    logic [2:0]  band;
    logic [23:0] exp_rgb;

    always_comb begin
        band = 3'd0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (32'(x_cur) >= i * BAND_W) begin
                band = band + 3'd1;
            end
        end
    end

    always_comb begin
        exp_rgb = 24'h000000;
        case (band)
            3'd0:    exp_rgb = 24'hFFFFFF;
            3'd1:    exp_rgb = 24'hFFFF00;
            3'd2:    exp_rgb = 24'h00FFFF;
            3'd3:    exp_rgb = 24'h00FF00;
            3'd4:    exp_rgb = 24'hFF00FF;
            3'd5:    exp_rgb = 24'hFF0000;
            3'd6:    exp_rgb = 24'h0000FF;
            default: exp_rgb = 24'h000000;
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel compare and error accounting
    // ------------------------------------------------------------------
    logic pix_mismatch;

    assign pix_mismatch = ({r_r, g_r, b_r} != exp_rgb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_err <= 1'b0;
        end else begin
            pix_err <= de_r & locked & pix_mismatch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (pix_err && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + EW'(1);
        end
    end

endmodule

// File: tb/tb_color_bar_check.sv
// Bench for color_bar_check using a scaled-down raster (16x4 active,
// 24x6 total) so whole frames run in a few hundred clocks.
module tb_color_bar_check;

    localparam int unsigned HA = 16;
    localparam int unsigned VA = 4;
    localparam int unsigned HT = 24;
    localparam int unsigned VT = 6;
    localparam int unsigned LF = 2;
    localparam int DE_START = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs, vs, de;
    logic [7:0]  rgb_r, rgb_g, rgb_b;
    logic        err_clr;
    logic [11:0] h_total_meas, h_active_meas, v_total_meas, v_active_meas;
    logic        locked, frame_done, pix_err;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    color_bar_check #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .de(de),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .err_clr(err_clr),
        .h_total_meas(h_total_meas), .h_active_meas(h_active_meas),
        .v_total_meas(v_total_meas), .v_active_meas(v_active_meas),
        .locked(locked), .frame_done(frame_done), .pix_err(pix_err),
        .err_cnt(err_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Cycle counter and pulse monitor
    int cyc = 0;
    int pe_seen = 0, fd_seen = 0;
    int pe_last_cyc = -1, fd_last_cyc = -1;
    int last_vs_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_err) begin
                pe_seen++;
                pe_last_cyc = cyc;
            end
            if (frame_done) begin
                fd_seen++;
                fd_last_cyc = cyc;
            end
        end
    end

    // Reference model state
    int m_frames = 0, m_run = 0, m_err = 0, m_pe = 0, m_fd = 0;
    bit m_prev_nom = 1'b0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] exp_pix(input int x);
        int k;
        k = (x >= int'(HA)) ? 7 : (x * 8) / int'(HA);
        return bars[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_htot"}, 32'(h_total_meas), 32'd0);
        chk({pfx, "_hact"}, 32'(h_active_meas), 32'd0);
        chk({pfx, "_vtot"}, 32'(v_total_meas), 32'd0);
        chk({pfx, "_vact"}, 32'(v_active_meas), 32'd0);
        chk({pfx, "_locked"}, 32'(locked), 32'd0);
        chk({pfx, "_fdone"}, 32'(frame_done), 32'd0);
        chk({pfx, "_pixerr"}, 32'(pix_err), 32'd0);
        chk({pfx, "_errcnt"}, 32'(err_cnt), 32'd0);
    endtask

    // One raster line. de_len > HA stretches the line so hs does not recur.
    task automatic drive_line(input bit vs_line, input int de_len, input int err_x,
                              input logic [23:0] err_mask, input int clr_pos,
                              output int err_cyc);
        int len;
        len = (de_len > int'(HA)) ? DE_START + de_len + 4 : int'(HT);
        err_cyc = -1;
        for (int p = 0; p < len; p++) begin
            logic [23:0] px;
            int x;
            @(negedge clk);
            hs = (p < 2);
            vs = vs_line && (p >= 2) && (p < 6);
            if (vs_line && p == 2) last_vs_cyc = cyc;
            err_clr = (p == clr_pos);
            if (p >= DE_START && p < DE_START + de_len) begin
                x  = p - DE_START;
                de = 1'b1;
                px = exp_pix(x);
                if (x == err_x) begin
                    px = px ^ err_mask;
                    err_cyc = cyc;
                end
            end else begin
                de = 1'b0;
                px = 24'($urandom);
            end
            {rgb_r, rgb_g, rgb_b} = px;
        end
    endtask

    task automatic drive_frame(input int n_lines, input bit long_last, input int err_lines,
                               input int err_x_fix, input logic [23:0] mask_fix,
                               input int clr_line, output int n_inj, output int ecyc);
        n_inj = 0;
        ecyc  = -1;
        for (int l = 0; l < n_lines; l++) begin
            bit act;
            int dl, ex, cp, c;
            logic [23:0] m;
            act = (l >= 1) && (l <= int'(VA));
            dl  = act ? int'(HA) : 0;
            if (long_last && l == n_lines - 1) dl = 5000;
            ex = -1;
            m  = 24'h0;
            cp = -1;
            if (act && err_lines[l]) begin
                ex = (err_x_fix >= 0) ? err_x_fix : int'($urandom_range(HA - 1));
                m  = (mask_fix != 24'h0) ? mask_fix : 24'($urandom_range(24'hFFFFFF, 1));
                n_inj++;
            end
            if (l == clr_line) cp = DE_START + ex + 2;
            drive_line(l == 0, dl, ex, m, cp, c);
            if (ex >= 0) ecyc = c;
        end
    endtask

    // Drives one frame and advances the reference model: each vs after the
    // first judges the previous frame; lock means LF consecutive good frames.
    task automatic run_frame(input int n_lines, input bit long_last, input int err_lines,
                             input int err_x, input logic [23:0] err_mask,
                             input int clr_line, output int ecyc);
        int n_inj;
        if (m_frames > 0) begin
            m_fd++;
            if (m_prev_nom) m_run++;
            else m_run = 0;
        end
        m_frames++;
        drive_frame(n_lines, long_last, err_lines, err_x, err_mask, clr_line, n_inj, ecyc);
        if (m_run >= int'(LF)) begin
            m_pe  += n_inj;
            m_err += n_inj;
        end
        if (clr_line >= 0) m_err = 0;
        m_prev_nom = (n_lines == int'(VT)) && !long_last;
    endtask

    function automatic bit m_locked();
        return m_run >= int'(LF);
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        hs = 1'b0; vs = 1'b0; de = 1'b0; err_clr = 1'b0;
        rgb_r = 8'd0; rgb_g = 8'd0; rgb_b = 8'd0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int ec, fd0, pe0, el, kind;

        // Reset state
        do_reset(4);
        chk_outputs_zero("reset");
        rst = 1'b0;
        m_frames = 0; m_run = 0; m_err = 0;

        // Nominal source from reset
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("fd_after_arm_frame", 32'(fd_seen), 32'd0);
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("fd_after_2nd_vs", 32'(fd_seen), 32'd1);
        chk("fd_latency", 32'(fd_last_cyc), 32'(last_vs_cyc + 3));
        chk("locked_after_1st_fd", 32'(locked), 32'd0);
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("locked_after_2nd_fd", 32'(locked), 32'd1);
        chk("h_total_meas", 32'(h_total_meas), 32'(HT));
        chk("h_active_meas", 32'(h_active_meas), 32'(HA));
        chk("v_total_meas", 32'(v_total_meas), 32'(VT));
        chk("v_active_meas", 32'(v_active_meas), 32'(VA));
        chk("nominal_pix_err", 32'(pe_seen), 32'd0);
        chk("nominal_err_cnt", 32'(err_cnt), 32'd0);

        // Black pixel in the yellow band
        run_frame(VT, 1'b0, 32'h2, int'(HA / 8), exp_pix(int'(HA / 8)), -1, ec);
        chk("single_err_pulses", 32'(pe_seen), 32'd1);
        chk("single_err_latency", 32'(pe_last_cyc), 32'(ec + 2));
        chk("single_err_cnt", 32'(err_cnt), 32'd1);

        // Accumulate to 5, then clear coincident with a pix_err
        run_frame(VT, 1'b0, 32'h1E, -1, 24'h0, -1, ec);
        chk("err_cnt_five", 32'(err_cnt), 32'd5);
        pe0 = pe_seen;
        run_frame(VT, 1'b0, 32'h4, -1, 24'h0, 2, ec);
        chk("clr_pix_err_seen", 32'(pe_seen), 32'(pe0 + 1));
        chk("clr_same_cycle", 32'(pe_last_cyc), 32'(ec + 2));
        chk("clr_wins", 32'(err_cnt), 32'd0);

        // Short frame drops lock; errors while unlocked are ignored
        run_frame(VT - 1, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("short_still_locked", 32'(locked), 32'd1);
        run_frame(VT, 1'b0, 32'h2, -1, 24'h0, -1, ec);
        chk("short_v_total", 32'(v_total_meas), 32'(VT - 1));
        chk("short_unlocked", 32'(locked), 32'd0);
        chk("unlocked_no_pix_err", 32'(pe_seen), 32'(m_pe));
        chk("unlocked_err_cnt", 32'(err_cnt), 32'(m_err));
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("relock_check_state", 32'(locked), 32'd0);
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("relocked", 32'(locked), 32'd1);

        // Over-long de run saturates h_active_meas
        run_frame(VT, 1'b1, 0, -1, 24'h0, -1, ec);
        chk("h_active_sat", 32'(h_active_meas), 32'd4095);
        chk("long_de_no_pix_err", 32'(pe_seen), 32'(m_pe));
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("long_de_unlocked", 32'(locked), 32'd0);
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("relocked_after_long", 32'(locked), 32'd1);

        // Randomised frame geometry and pixel corruption
        for (int i = 0; i < 14; i++) begin
            kind = int'($urandom_range(9));
            el   = int'($urandom_range(31)) & 32'h1E;
            if (kind == 0) run_frame(VT - 1, 1'b0, el, -1, 24'h0, -1, ec);
            else if (kind == 1) run_frame(VT + 1, 1'b0, el, -1, 24'h0, -1, ec);
            else run_frame(VT, 1'b0, el, -1, 24'h0, -1, ec);
            chk("rnd_locked", 32'(locked), 32'(m_locked()));
            chk("rnd_err_cnt", 32'(err_cnt), 32'(m_err));
            chk("rnd_pix_err", 32'(pe_seen), 32'(m_pe));
            chk("rnd_frame_done", 32'(fd_seen), 32'(m_fd));
        end

        // Reset mid-frame
        begin
            int c;
            drive_line(1'b1, 0, -1, 24'h0, -1, c);
            drive_line(1'b0, int'(HA), -1, 24'h0, -1, c);
            drive_line(1'b0, int'(HA), -1, 24'h0, -1, c);
        end
        do_reset(3);
        chk_outputs_zero("midrst");
        rst = 1'b0;
        m_frames = 0; m_run = 0; m_err = 0;
        fd0 = fd_seen;
        m_fd = fd_seen;
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("midrst_arm_only", 32'(fd_seen), 32'(fd0));
        run_frame(VT, 1'b0, 0, -1, 24'h0, -1, ec);
        chk("midrst_first_fd", 32'(fd_seen), 32'(fd0 + 1));
        chk("midrst_not_locked", 32'(locked), 32'd0);
        run_frame(VT, 1'b0, 32'h8, -1, 24'h0, -1, ec);
        chk("midrst_relocked", 32'(locked), 32'd1);
        chk("midrst_err_cnt", 32'(err_cnt), 32'(m_err));
        chk("midrst_pix_err", 32'(pe_seen), 32'(m_pe));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
